// File: rtl/rf_mp_pkg.sv
// Shared definitions for the multi-port register file.
//   rf_state_e  : control FSM encoding (INIT sweep, RUN)
//   INIT_ZERO / INIT_INDEX : INIT_MODE codes (all zero, entry i holds i)
//   byte_merge  : one byte lane of the byte-enable write merge
package rf_mp_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rf_state_e;

  localparam int INIT_ZERO  = 0;
  localparam int INIT_INDEX = 1;

  function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       en);
    return en ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/rf_init_seq.sv
// Initialisation sequencer for rf_mp: sweeps every entry once after reset,
// then enables normal operation.
//   CLK, RST_N : clock, async active-low reset
//   W          : write request (used only to flag writes made before READY)
//   ready      : registered, high exactly in RUN
//   w_err      : one-cycle pulse after a write requested while not ready
//   init_we    : array write strobe during the sweep
//   init_addr  : entry being initialised this cycle
//
// state   | meaning
// --------+---------------------------------------------------
// ST_INIT | sweeping entries 0..DEPTH-1, one per cycle
// ST_RUN  | sweep complete, file accepts writes
module rf_init_seq
  import rf_mp_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  W,
  output logic                  ready,
  output logic                  w_err,
  output logic                  init_we,
  output logic [ADDR_WIDTH-1:0] init_addr
);

  rf_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_we = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_we = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = ST_RUN;
      end
      ST_RUN: ;
      default: state_d = ST_INIT;
    endcase
  end

  assign init_addr = cnt_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready   <= 1'b0;
      w_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Registered from next state so READY tracks RUN with no lag.
      ready   <= (state_d == ST_RUN);
      w_err   <= W && !ready;
    end
  end

endmodule

// File: rtl/rf_mp.sv
// Multi-port register file with byte-enable writes, optional hardwired
// zero entry, optional write-to-read forwarding and a power-up init sweep.
//   CLK, RST_N : clock, async active-low reset (array itself is not reset)
//   W, W_Reg, W_data, W_BE : write request, address, data, byte enables
//   R_Reg      : NUM_READ packed read addresses, port p at bits p*ADDR_WIDTH
//   R_data     : NUM_READ packed read words, same packing
//   READY      : initialisation finished, writes accepted
//   W_ERR      : pulse one cycle after a write was dropped for !READY
module rf_mp
  import rf_mp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1,
  parameter int INIT_MODE  = 0,
  parameter int BYPASS     = 1
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic                           W,
  input  logic [ADDR_WIDTH-1:0]          W_Reg,
  input  logic [DATA_WIDTH-1:0]          W_data,
  input  logic [DATA_WIDTH/8-1:0]        W_BE,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] R_Reg,
  output logic [NUM_READ*DATA_WIDTH-1:0] R_data,
  output logic                           READY,
  output logic                           W_ERR
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  init_we;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic [DATA_WIDTH-1:0] init_word;
  logic [DATA_WIDTH-1:0] wr_old;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic                  wr_en;

  rf_init_seq #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_init_seq (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .W        (W),
    .ready    (READY),
    .w_err    (W_ERR),
    .init_we  (init_we),
    .init_addr(init_addr)
  );

  assign init_word = (INIT_MODE == INIT_INDEX) ? DATA_WIDTH'(init_addr) : '0;

  // Merged word feeds both the array write and the forwarding path, so a
  // bypassed read matches exactly what lands in the array.
  assign wr_old = mem[W_Reg];
  for (genvar k = 0; k < NB; k++) begin : g_merge
    assign wr_merged[8*k +: 8] = byte_merge(wr_old[8*k +: 8], W_data[8*k +: 8], W_BE[k]);
  end

  // READY drops asynchronously with reset, so a write in flight is discarded.
  assign wr_en = READY && W && !(ZERO_REG != 0 && W_Reg == '0);

  always_ff @(posedge CLK) begin
    if (init_we) begin
      mem[init_addr] <= init_word;
    end else if (wr_en) begin
      mem[W_Reg] <= wr_merged;
    end
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] rd;

    assign raddr = R_Reg[p*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rd = '0;
      if (READY) begin
        if (ZERO_REG != 0 && raddr == '0) begin
          rd = '0;
        end else if (BYPASS != 0 && W && raddr == W_Reg) begin
          rd = wr_merged;
        end else begin
          rd = mem[raddr];
        end
      end
    end

    assign R_data[p*DATA_WIDTH +: DATA_WIDTH] = rd;
  end

endmodule

// File: tb/tb_rf_mp.sv
module tb_rf_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 4;
  localparam int DEPTH = 32;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              W;
  logic [AW-1:0]     W_Reg;
  logic [DW-1:0]     W_data;
  logic [DW/8-1:0]   W_BE;
  logic [NR*AW-1:0]  R_Reg;
  logic [NR*DW-1:0]  rd_a, rd_b;
  logic              ready_a, ready_b, werr_a, werr_b;

  always #5 CLK = ~CLK;

  // dut_a: index init, forwarding on. dut_b: zero init, forwarding off.
  rf_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .ZERO_REG(1),
          .INIT_MODE(1), .BYPASS(1)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .W(W), .W_Reg(W_Reg), .W_data(W_data),
    .W_BE(W_BE), .R_Reg(R_Reg), .R_data(rd_a), .READY(ready_a), .W_ERR(werr_a));

  rf_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .ZERO_REG(1),
          .INIT_MODE(0), .BYPASS(0)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .W(W), .W_Reg(W_Reg), .W_data(W_data),
    .W_BE(W_BE), .R_Reg(R_Reg), .R_data(rd_b), .READY(ready_b), .W_ERR(werr_b));

  typedef struct {
    int          d;
    int          p;
    logic [31:0] v;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] mdl [2][DEPTH];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = data[8*k +: 8];
    return r;
  endfunction

  function automatic void init_model();
    for (int i = 0; i < DEPTH; i++) begin
      mdl[0][i] = 32'(i);
      mdl[1][i] = 32'h0;
    end
  endfunction

  // Expected read given the current write inputs; only dut_a forwards.
  function automatic logic [31:0] exp_rd(input int d, input int addr);
    if (addr == 0) return 32'h0;
    if (d == 0 && W && addr == int'(W_Reg)) return merge(mdl[d][addr], W_data, W_BE);
    return mdl[d][addr];
  endfunction

  function automatic void push_model();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < NR; p++)
        exp_q.push_back('{d: d, p: p, v: exp_rd(d, int'(R_Reg[p*AW +: AW]))});
  endfunction

  function automatic void commit_write();
    if (W && W_Reg != 0)
      for (int d = 0; d < 2; d++) mdl[d][W_Reg] = merge(mdl[d][W_Reg], W_data, W_BE);
  endfunction

  function automatic logic [31:0] got(input int d, input int p);
    return (d == 0) ? rd_a[p*DW +: DW] : rd_b[p*DW +: DW];
  endfunction

  function automatic void set_all_ports(input logic [AW-1:0] a);
    for (int p = 0; p < NR; p++) R_Reg[p*AW +: AW] = a;
  endfunction

  task automatic test_reset();
    RST_N = 1'b0; W = 1'b0; W_Reg = '0; W_data = '0; W_BE = '0;
    set_all_ports(5'd3);
    #3;
    n_checks++;
    if (ready_a !== 1'b0 || ready_b !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b/%b expected 0/0", ready_a, ready_b);
    end
    n_checks++;
    if (werr_a !== 1'b0 || werr_b !== 1'b0) begin
      n_fail++; $display("FAIL reset_werr: got %b/%b expected 0/0", werr_a, werr_b);
    end
    for (int d = 0; d < 2; d++) for (int p = 0; p < NR; p++) exp_q.push_back('{d: d, p: p, v: 32'h0});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (got(e.d, e.p) !== e.v) begin
        n_fail++; $display("FAIL reset_rdata dut%0d port%0d: got %h expected %h", e.d, e.p, got(e.d, e.p), e.v);
      end
    end
    repeat (2) @(posedge CLK);
  endtask

  // Release reset; write to r3 at cycle 10 must be dropped and flagged.
  task automatic test_init_sweep();
    @(negedge CLK);
    RST_N = 1'b1;
    init_model();
    W_Reg = 5'd3; W_data = 32'hFFFF_FFFF; W_BE = 4'hF;
    set_all_ports(5'd3);
    for (int k = 1; k <= 34; k++) begin
      W = (k == 10);
      @(posedge CLK);
      @(negedge CLK);
      W = 1'b0;
      #1;
      n_checks++;
      if (ready_a !== (k >= 32) || ready_b !== (k >= 32)) begin
        n_fail++; $display("FAIL init_ready cycle %0d: got %b/%b expected %b", k, ready_a, ready_b, k >= 32);
      end
      n_checks++;
      if (werr_a !== (k == 10) || werr_b !== (k == 10)) begin
        n_fail++; $display("FAIL init_werr cycle %0d: got %b/%b expected %b", k, werr_a, werr_b, k == 10);
      end
      if (k == 31 || k == 32 || k == 34) begin
        for (int d = 0; d < 2; d++)
          for (int p = 0; p < NR; p++)
            exp_q.push_back('{d: d, p: p, v: (k < 32) ? 32'h0 : ((d == 0) ? 32'h3 : 32'h0)});
        while (exp_q.size() > 0) begin
          e = exp_q.pop_front(); n_checks++;
          if (got(e.d, e.p) !== e.v) begin
            n_fail++; $display("FAIL init_r3 cycle %0d dut%0d port%0d: got %h expected %h", k, e.d, e.p, got(e.d, e.p), e.v);
          end
        end
      end
    end
  endtask

  task automatic test_init_values();
    @(negedge CLK);
    R_Reg[0*AW +: AW] = 5'd7;
    R_Reg[1*AW +: AW] = 5'd0;
    R_Reg[2*AW +: AW] = 5'd31;
    R_Reg[3*AW +: AW] = 5'd7;
    #1;
    exp_q.push_back('{d: 0, p: 0, v: 32'h0000_0007});
    exp_q.push_back('{d: 0, p: 1, v: 32'h0000_0000});
    exp_q.push_back('{d: 0, p: 2, v: 32'h0000_001F});
    exp_q.push_back('{d: 0, p: 3, v: 32'h0000_0007});
    for (int p = 0; p < NR; p++) exp_q.push_back('{d: 1, p: p, v: 32'h0});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (got(e.d, e.p) !== e.v) begin
        n_fail++; $display("FAIL init_values dut%0d port%0d: got %h expected %h", e.d, e.p, got(e.d, e.p), e.v);
      end
    end
  endtask

  task automatic test_byte_write();
    @(negedge CLK);
    W = 1'b1; W_Reg = 5'd5; W_data = 32'hDEAD_BEEF; W_BE = 4'b0101;
    set_all_ports(5'd5);
    #1;
    for (int p = 0; p < NR; p++) begin
      exp_q.push_back('{d: 0, p: p, v: 32'h00AD_00EF});
      exp_q.push_back('{d: 1, p: p, v: 32'h0000_0000});
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (got(e.d, e.p) !== e.v) begin
        n_fail++; $display("FAIL byte_write_same_cycle dut%0d port%0d: got %h expected %h", e.d, e.p, got(e.d, e.p), e.v);
      end
    end
    commit_write();
    @(negedge CLK);
    W = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) exp_q.push_back('{d: d, p: 2, v: 32'h00AD_00EF});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (got(e.d, e.p) !== e.v) begin
        n_fail++; $display("FAIL byte_write_after dut%0d port%0d: got %h expected %h", e.d, e.p, got(e.d, e.p), e.v);
      end
    end
    n_checks++;
    if (werr_a !== 1'b0 || werr_b !== 1'b0) begin
      n_fail++; $display("FAIL byte_write_werr: got %b/%b expected 0/0", werr_a, werr_b);
    end
  endtask

  task automatic test_be_zero();
    @(negedge CLK);
    W = 1'b1; W_Reg = 5'd7; W_data = 32'hFFFF_FFFF; W_BE = 4'h0;
    set_all_ports(5'd7);
    #1;
    push_model();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (got(e.d, e.p) !== e.v) begin
        n_fail++; $display("FAIL be_zero_same dut%0d port%0d: got %h expected %h", e.d, e.p, got(e.d, e.p), e.v);
      end
    end
    commit_write();
    @(negedge CLK);
    W = 1'b0;
    #1;
    exp_q.push_back('{d: 0, p: 1, v: 32'h0000_0007});
    exp_q.push_back('{d: 1, p: 1, v: 32'h0000_0000});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (got(e.d, e.p) !== e.v) begin
        n_fail++; $display("FAIL be_zero_after dut%0d port%0d: got %h expected %h", e.d, e.p, got(e.d, e.p), e.v);
      end
    end
    n_checks++;
    if (werr_a !== 1'b0 || werr_b !== 1'b0) begin
      n_fail++; $display("FAIL be_zero_werr: got %b/%b expected 0/0", werr_a, werr_b);
    end
  endtask

  task automatic test_zero_reg();
    @(negedge CLK);
    W = 1'b1; W_Reg = 5'd0; W_data = 32'hFFFF_FFFF; W_BE = 4'hF;
    set_all_ports(5'd0);
    for (int c = 0; c < 2; c++) begin
      #1;
      for (int d = 0; d < 2; d++) for (int p = 0; p < NR; p++) exp_q.push_back('{d: d, p: p, v: 32'h0});
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); n_checks++;
        if (got(e.d, e.p) !== e.v) begin
          n_fail++; $display("FAIL zero_reg phase%0d dut%0d port%0d: got %h expected %h", c, e.d, e.p, got(e.d, e.p), e.v);
        end
      end
      @(negedge CLK);
      W = 1'b0;
    end
  endtask

  task automatic test_bypass_off();
    @(negedge CLK);
    W = 1'b1; W_Reg = 5'd12; W_data = 32'hA5A5_A5A5; W_BE = 4'hF;
    set_all_ports(5'd12);
    #1;
    for (int p = 0; p < NR; p++) begin
      exp_q.push_back('{d: 0, p: p, v: 32'hA5A5_A5A5});
      exp_q.push_back('{d: 1, p: p, v: 32'h0000_0000});
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (got(e.d, e.p) !== e.v) begin
        n_fail++; $display("FAIL bypass_same dut%0d port%0d: got %h expected %h", e.d, e.p, got(e.d, e.p), e.v);
      end
    end
    commit_write();
    @(negedge CLK);
    W = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) for (int p = 0; p < NR; p++) exp_q.push_back('{d: d, p: p, v: 32'hA5A5_A5A5});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (got(e.d, e.p) !== e.v) begin
        n_fail++; $display("FAIL bypass_next dut%0d port%0d: got %h expected %h", e.d, e.p, got(e.d, e.p), e.v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] prev;
    prev = 5'd5;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      W      = 1'b1;
      W_Reg  = AW'($urandom_range(1, DEPTH - 1));
      W_data = $urandom;
      W_BE   = 4'($urandom_range(0, 15));
      R_Reg[0*AW +: AW] = W_Reg;
      R_Reg[1*AW +: AW] = prev;
      R_Reg[2*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
      R_Reg[3*AW +: AW] = W_Reg;
      #1;
      push_model();
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); n_checks++;
        if (got(e.d, e.p) !== e.v) begin
          n_fail++; $display("FAIL back_to_back step%0d dut%0d port%0d: got %h expected %h", c, e.d, e.p, got(e.d, e.p), e.v);
        end
      end
      commit_write();
      prev = W_Reg;
    end
    @(negedge CLK);
    W = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int first_k;
    @(negedge CLK);
    W = 1'b1; W_Reg = 5'd9; W_data = 32'h1234_5678; W_BE = 4'hF;
    commit_write();
    @(negedge CLK);
    W = 1'b0;
    set_all_ports(5'd9);
    #1;
    for (int d = 0; d < 2; d++) exp_q.push_back('{d: d, p: 0, v: 32'h1234_5678});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (got(e.d, e.p) !== e.v) begin
        n_fail++; $display("FAIL mid_run_r9_written dut%0d: got %h expected %h", e.d, got(e.d, e.p), e.v);
      end
    end
    @(negedge CLK);
    W = 1'b1; W_data = 32'hCAFE_F00D;
    #2;
    RST_N = 1'b0;
    #1;
    n_checks++;
    if (ready_a !== 1'b0 || ready_b !== 1'b0 || werr_a !== 1'b0 || werr_b !== 1'b0) begin
      n_fail++; $display("FAIL mid_run_async: ready %b/%b werr %b/%b expected all 0", ready_a, ready_b, werr_a, werr_b);
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    W = 1'b0;
    RST_N = 1'b1;
    init_model();
    first_k = 0;
    for (int k = 1; k <= 40 && first_k == 0; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (ready_a === 1'b1) first_k = k;
    end
    n_checks++;
    if (first_k != 32 || ready_b !== 1'b1) begin
      n_fail++; $display("FAIL mid_run_resweep: ready rose after %0d cycles (0 = never) dut_b %b, expected 32 and 1", first_k, ready_b);
    end
    #1;
    exp_q.push_back('{d: 0, p: 1, v: 32'h0000_0009});
    exp_q.push_back('{d: 1, p: 1, v: 32'h0000_0000});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (got(e.d, e.p) !== e.v) begin
        n_fail++; $display("FAIL mid_run_r9_reinit dut%0d: got %h expected %h", e.d, got(e.d, e.p), e.v);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_init_sweep();
    test_init_values();
    test_byte_write();
    test_be_zero();
    test_zero_reg();
    test_bypass_off();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
